// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU sequencer that borrows the shared ALU while busy and
// otherwise passes the core's operands straight through to it.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] core_in1,
  input  logic [WIDTH-1:0] core_in2,
  input  logic [5:0]       core_ctrl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [5:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;

  // Working registers are shared: acc/plo/mcand for MULTU, rem/quo/dvsr for DIVU.
  logic [WIDTH-1:0] wrk_hi, wrk_lo, wrk_op;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] sh;
  logic             carry;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));
  assign sh   = {wrk_hi[WIDTH-2:0], wrk_lo[WIDTH-1]};
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    alu_in1 = core_in1;
    alu_in2 = core_in2;
    alu_ctrl = core_ctrl;
    hi_nxt = wrk_hi;
    lo_nxt = wrk_lo;
    carry = 1'b0;
    case (state)
      MUL: begin
        alu_in1 = wrk_hi;
        alu_in2 = wrk_lo[0] ? wrk_op : '0;
        alu_ctrl = FN_ADD;
        // The ALU drops the carry-out; recover it from unsigned wrap-around.
        carry = (alu_out < wrk_hi);
        {hi_nxt, lo_nxt} = {carry, alu_out, wrk_lo[WIDTH-1:1]};
      end
      DIV: begin
        alu_in1 = sh;
        alu_in2 = wrk_op;
        alu_ctrl = FN_SUB;
        // A set bit shifted out of rem means the true partial remainder exceeds dvsr.
        if (wrk_hi[WIDTH-1] || (sh >= wrk_op)) begin
          hi_nxt = alu_out;
          lo_nxt = {wrk_lo[WIDTH-2:0], 1'b1};
        end else begin
          hi_nxt = sh;
          lo_nxt = {wrk_lo[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = op ? DIV : MUL;
      MUL, DIV: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wrk_hi <= '0;
      wrk_lo <= '0;
      wrk_op <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            wrk_hi <= '0;
            wrk_lo <= op ? opa : opb;
            wrk_op <= op ? opb : opa;
            cnt <= '0;
          end
        end
        MUL, DIV: begin
          wrk_hi <= hi_nxt;
          wrk_lo <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] opa = '0, opb = '0;
  logic [WIDTH-1:0] core_in1 = '0, core_in2 = '0;
  logic [5:0]       core_ctrl = '0;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
  logic [5:0]       alu_ctrl;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: add, sub, otherwise AND.
  assign alu_out = (alu_ctrl == FN_ADD) ? alu_in1 + alu_in2 :
                   (alu_ctrl == FN_SUB) ? alu_in1 - alu_in2 : (alu_in1 & alu_in2);

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .core_in1(core_in1), .core_in2(core_in2), .core_ctrl(core_ctrl),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic watch_no_done(input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("stray_done", pulses, 0);
    check("idle_busy", busy, 0);
  endtask

  // Runs one operation; inj >= 0 pulses a second start mid-run, abort_at >= 0 resets mid-run.
  task automatic run_op(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int inj, input int abort_at);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] eh, el;
    int k, nbusy;
    bit aborted;
    if (!o) begin
      prod = 64'(a) * 64'(b);
      eh = prod[2*WIDTH-1:WIDTH];
      el = prod[WIDTH-1:0];
    end else if (b == 0) begin
      eh = a;
      el = '1;
    end else begin
      eh = a % b;
      el = a / b;
    end
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom;
    k = 0; nbusy = 0; aborted = 1'b0;
    while (!done && k < 100 && !aborted) begin
      nbusy += int'(busy);
      if (k < WIDTH) check("seq_ctrl", alu_ctrl, o ? FN_SUB : FN_ADD);
      core_in1 = $urandom; core_in2 = $urandom; core_ctrl = 6'($urandom);
      if (k == inj) begin
        start = 1'b1; op = ~o; opa = $urandom; opb = $urandom;
      end else begin
        start = 1'b0;
      end
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_mux", alu_in1, core_in1);
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    if (aborted) begin
      watch_no_done(40);
    end else begin
      check("latency", k, WIDTH);
      check("busy_cycles", nbusy + int'(busy), WIDTH + 1);
      check(o ? "div_hi" : "mul_hi", hi, eh);
      check(o ? "div_lo" : "mul_lo", lo, el);
      check("done_mux_in1", alu_in1, core_in1);
      check("done_mux_ctrl", alu_ctrl, core_ctrl);
      @(negedge clk);
      check("done_width", done, 0);
      check("busy_clear", busy, 0);
      if (inj >= 0) watch_no_done(40);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;

    core_in1 = 5; core_in2 = 3; core_ctrl = FN_SUB;
    #1;
    check("idle_in1", alu_in1, 5);
    check("idle_in2", alu_in2, 3);
    check("idle_ctrl", alu_ctrl, FN_SUB);

    run_op(1'b0, 32'd7, 32'd6, -1, -1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    run_op(1'b1, 32'd100, 32'd7, -1, -1);
    run_op(1'b1, 32'h8000_0000, 32'd3, -1, -1);
    run_op(1'b1, 32'h1234_5678, 32'd0, -1, -1);
    run_op(1'b0, 32'hDEAD_BEEF, 32'h0001_2345, 5, -1);
    run_op(1'b1, 32'hCAFE_F00D, 32'd1234, 17, -1);

    run_op(1'b1, 32'h5555_AAAA, 32'h0001_0000, -1, -1);
    run_op(1'b0, $urandom, $urandom, -1, 10);
    run_op(1'b1, 32'd9, 32'd2, -1, -1);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 4) == 0) a = WIDTH'($urandom_range(0, 255));
      run_op(1'($urandom_range(0, 1)), a, b,
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle HI/LO unit. It executes MULTU and DIVU by iterating the shared 32-bit ALU: shift-add for multiply, restoring subtract for divide.
- Arbitrates the ALU operand/control inputs between the single-cycle core path and itself. While idle, core operands pass through unchanged. While busy, the core is stalled and the sequencer owns the ALU.
- Sits between the decode/ALU-control logic and the ALU. HI/LO feed MFHI/MFLO.

Parameters:
WIDTH, 32, operand/ALU width; also the iteration count. The counter is clog2(WIDTH) bits.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  1  0 = MULTU, 1 = DIVU
opa  input  WIDTH  multiplicand / dividend
opb  input  WIDTH  multiplier / divisor
core_in1  input  WIDTH  core ALU operand 1
core_in2  input  WIDTH  core ALU operand 2
core_ctrl  input  6  core ALU function code
alu_in1  output  WIDTH  to ALU in1
alu_in2  output  WIDTH  to ALU in2
alu_ctrl  output  6  to ALU function select
alu_out  input  WIDTH  from ALU result
busy  output  1  high in MUL, DIV and DONE; doubles as core stall
done  output  1  one-cycle pulse in DONE
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; hi = lo = 0; busy = done = 0; counter and internal registers = 0.
  - Reset asserted mid-operation aborts it: the next edge returns to IDLE and HI/LO are cleared.
- ALU function codes: add = 6'b100000, sub = 6'b100010.
- ALU mux (combinational):
  - In IDLE and DONE: alu_in1/alu_in2/alu_ctrl = core_in1/core_in2/core_ctrl.
  - In MUL/DIV: the sequencer drives them.
- State machine: IDLE, MUL, DIV, DONE.
  - IDLE: if start, load working registers, cnt = 0, go to MUL (op = 0) or DIV (op = 1). Otherwise stay.
  - MUL/DIV: perform one iteration per clock and increment cnt. At cnt = WIDTH-1, do the final iteration, write hi/lo, and go to DONE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- start while busy is ignored and not queued. start is evaluated again on the first IDLE cycle.
- Latency: start sampled at edge N; hi/lo updated at edge N+WIDTH; done high during the cycle after edge N+WIDTH. busy low again after edge N+WIDTH+1.
- MULTU, registers acc (W), plo (W), mcand (W):
  - Load: acc = 0, plo = opb, mcand = opa.
  - Each iteration: alu_in1 = acc, alu_in2 = plo[0] ? mcand : 0, ctrl = add.
  - Carry c = (alu_out < acc), unsigned compare.
  - Update: {acc, plo} <= {c, alu_out, plo[W-1:1]}.
  - Final: hi = acc, lo = plo (full 2W-bit unsigned product).
- DIVU, registers rem (W), quo (W), dvsr (W):
  - Load: rem = 0, quo = opa, dvsr = opb.
  - Each iteration: sh = {rem[W-2:0], quo[W-1]}, t = rem[W-1].
  - alu_in1 = sh, alu_in2 = dvsr, ctrl = sub.
  - If t | (sh >= dvsr, unsigned): rem <= alu_out, quo <= {quo[W-2:0], 1}.
  - Else: rem <= sh, quo <= {quo[W-2:0], 0}.
  - Final: hi = remainder, lo = quotient.
- Divide by zero is not special-cased. The algorithm naturally yields lo = all ones, hi = dividend, and this is the required result.
- The ALU sign interpretation is irrelevant: only the modulo-2^W add/sub result is used.
- ALU zero flag is unused by this block.
- HI/LO hold their values until the next completed operation or reset. An aborted operation never partially updates them.

Test Plan:
- MULTU 7 x 6: start at edge N -> hi = 0, lo = 42; done pulses in the cycle after edge N+32; busy high for 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001 (exercises the carry path every iteration).
- DIVU 100 / 7 -> lo = 14, hi = 2. DIVU 0x80000000 / 3 -> lo = 0x2AAAAAAA, hi = 2.
- DIVU 0x12345678 / 0 -> lo = 0xFFFFFFFF, hi = 0x12345678.
- Arbitration:
  - In IDLE, core_in1 = 5, core_in2 = 3, core_ctrl = sub -> alu ports mirror the core values.
  - During MUL, changing core inputs has no effect on alu ports or on the result.
  - A start pulse mid-operation is ignored: exactly one done pulse occurs and the results match the first operands.
- rst asserted at iteration 10 of a MULTU, with prior hi/lo = 0xAAAA/0x5555 -> next edge gives IDLE, hi = lo = 0, busy = 0, no done pulse. A following DIVU 9/2 gives lo = 4, hi = 1.
